// File: rtl/mealy_seq_det_pkg.sv
// Shared types and constants for the 1-1-0-1 Mealy sequence detector.
package mealy_seq_det_pkg;

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } state_t;

  localparam logic [3:0] PATTERN = 4'b1101;

endpackage

// File: rtl/mealy_seq_detector.sv
// Overlapping Mealy detector for the serial pattern 1-1-0-1 (first bit first).
// Optional wrapping match counter enabled by defining MEALY_SEQ_DET_CNT_EN.
module mealy_seq_detector
  import mealy_seq_det_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i,
  output logic             out
`ifdef MEALY_SEQ_DET_CNT_EN
  ,
  output logic [CNT_W-1:0] match_cnt
`endif
);

  state_t state;
  state_t next_state;

  if (CNT_W == 0) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S0;
`ifdef MEALY_SEQ_DET_CNT_EN
      match_cnt <= '0;
`endif
    end else begin
      state <= next_state;
`ifdef MEALY_SEQ_DET_CNT_EN
      if (out) begin
        match_cnt <= match_cnt + CNT_W'(1);
      end
`endif
    end
  end

  // Reset forces S0, so out is held low during reset without extra gating.
  always_comb begin
    next_state = state;
    out        = 1'b0;
    case (state)
      S0: next_state = (i == PATTERN[3]) ? S1 : S0;
      S1: next_state = (i == PATTERN[2]) ? S2 : S0;
      S2: next_state = (i == PATTERN[1]) ? S3 : S2;
      S3: begin
        if (i == PATTERN[0]) begin
          next_state = S1;
          out        = 1'b1;
        end else begin
          next_state = S0;
        end
      end
      default: next_state = S0;
    endcase
  end

endmodule

// File: tb/tb_mealy_seq_detector.sv
// Self-checking bench for mealy_seq_detector; reference is a 3-bit history window.
module tb_mealy_seq_detector;

  localparam int unsigned CNT_W = 2;

  logic clk;
  logic rst;
  logic i;
  logic out;
`ifdef MEALY_SEQ_DET_CNT_EN
  logic [CNT_W-1:0] match_cnt;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model: last three consumed bits and how many are valid since reset.
  logic [2:0]  hist;
  int unsigned nvalid;
  int unsigned cnt_exp;

  mealy_seq_detector #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .i         (i),
    .out       (out)
`ifdef MEALY_SEQ_DET_CNT_EN
    ,
    .match_cnt (match_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic logic model_out(input logic b);
    return (nvalid >= 3) && (hist == 3'b110) && b;
  endfunction

  task automatic model_clear();
    hist    = '0;
    nvalid  = 0;
    cnt_exp = 0;
  endtask

  // Entered and left on a falling edge: drive bit, check out, let the rising edge consume it.
  task automatic step(input logic b, output logic o);
    logic exp_o;
    i = b;
    #2;
    exp_o = model_out(b);
    o = out;
    check("out", 32'(out), 32'(exp_o));
    @(posedge clk);
    #1;
    hist = {hist[1:0], b};
    if (nvalid < 3) nvalid++;
    cnt_exp = (cnt_exp + 32'(exp_o)) % (32'd1 << CNT_W);
`ifdef MEALY_SEQ_DET_CNT_EN
    check("match_cnt", 32'(match_cnt), cnt_exp);
`endif
    @(negedge clk);
  endtask

  // Asserts reset between edges, holds it for ncyc clocks with i=1, releases on a falling edge.
  task automatic apply_reset(input int unsigned ncyc);
    #3;
    rst = 1'b0;
    model_clear();
    for (int unsigned c = 0; c < ncyc; c++) begin
      i = 1'b1;
      #1;
      check("out_in_reset", 32'(out), 32'd0);
`ifdef MEALY_SEQ_DET_CNT_EN
      check("cnt_in_reset", 32'(match_cnt), 32'd0);
`endif
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
  endtask

  task automatic run_seq(input string tag, input logic [15:0] bits, input int unsigned len,
                         input logic [15:0] exp_mask);
    logic [15:0] m;
    logic        o;
    m = '0;
    for (int unsigned k = 0; k < len; k++) begin
      step(bits[4'(len - 1 - k)], o);
      if (o) m[4'(k)] = 1'b1;
    end
    check(tag, 32'(m), 32'(exp_mask));
  endtask

  initial begin
    logic o;
    rst = 1'b0;
    i   = 1'b1;
    model_clear();
    @(negedge clk);

    apply_reset(3);

    run_seq("t2_1101", 16'b1101, 4, 16'h0008);

    apply_reset(1);
    run_seq("t3_overlap", 16'b1101101, 7, 16'h0048);
`ifdef MEALY_SEQ_DET_CNT_EN
    check("t3_cnt", 32'(match_cnt), 32'd2);
`endif

    apply_reset(1);
    run_seq("t4_11101", 16'b11101, 5, 16'h0010);
    apply_reset(1);
    run_seq("t4_nomatch", 16'b1011001, 7, 16'h0000);

    apply_reset(1);
    run_seq("t5_prefix", 16'b110, 3, 16'h0000);
    apply_reset(2);
    run_seq("t5_after_reset", 16'b1, 1, 16'h0000);

    apply_reset(1);
    run_seq("t6_five", 16'b1101101101101101, 16, 16'h9248);
`ifdef MEALY_SEQ_DET_CNT_EN
    check("t6_wrap_cnt", 32'(match_cnt), 32'd1);
`endif

    for (int unsigned k = 0; k < 400; k++) begin
      if ($urandom_range(0, 59) == 0) apply_reset($urandom_range(1, 2));
      step(1'($urandom_range(0, 1)), o);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
